// File: rtl/spi_controller_pkg.sv
// rtl/spi_controller_pkg.sv - shared types and helpers for the SPI initiator
// Purpose: FSM state type and a constant helper used to size the shared timing counter.
// Ports: none (package).
package spi_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } spi_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - mode-0 SPI initiator, MSB first, active-low chip select
// Purpose: shifts bytes from a valid/ready command stream out on spi_sdo while sampling spi_sdi,
//   returning each received byte as a one-cycle strobe. CS stays low across a frame until a byte
//   tagged last has shifted, then honours hold and idle gap timing.
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   tx_data/tx_last/tx_valid/tx_ready   byte command stream (accept on tx_valid && tx_ready)
//   rx_data/rx_strobe       received byte, valid for the one cycle rx_strobe is high
//   busy                    high from byte accept until the CS idle gap completes
//   spi_sck/spi_cs/spi_sdo  registered SPI outputs; spi_sdi SPI input (registered once before use)
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int CLOCKS_PER_HALF_BIT = 4,
  parameter int CS_SETUP_CLOCKS     = 4,
  parameter int CS_HOLD_CLOCKS      = 4,
  parameter int CS_IDLE_CLOCKS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_cs,
  output logic       spi_sdo,
  input  logic       spi_sdi
);

  localparam int CNT_MAX = max_of(max_of(CLOCKS_PER_HALF_BIT, CS_SETUP_CLOCKS),
                                  max_of(CS_HOLD_CLOCKS, CS_IDLE_CLOCKS));
  localparam int CW = $clog2(CNT_MAX) + 1;

  // The counter is loaded with N-1 so a phase lasts exactly N cycles, ending on the zero cycle.
  localparam logic [CW-1:0] HALF_LOAD  = CW'(CLOCKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP_CLOCKS - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(CS_HOLD_CLOCKS - 1);
  localparam logic [CW-1:0] IDLE_LOAD  = CW'(CS_IDLE_CLOCKS - 1);

  spi_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic          last_q, last_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_strobe_q, rx_strobe_d;
  logic          sck_q, sck_d;
  logic          cs_q, cs_d;
  logic          sdo_q, sdo_d;
  logic          busy_q, busy_d;
  logic          sdi_q;

  logic          accept;
  logic          cnt_zero;
  logic [CW-1:0] cnt_dec;

  // Only IDLE and WAIT can take a byte; there is no skid buffer, so the source holds tx_valid.
  assign tx_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_WAIT));
  assign accept   = tx_valid && tx_ready;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_sr_d     = tx_sr_q;
    last_d      = last_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    sck_d       = sck_q;
    cs_d        = cs_q;
    sdo_d       = sdo_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_sr_d = tx_data;
          last_d  = tx_last;
          sdo_d   = tx_data[7];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = 3'd0;
          cnt_d   = SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end

      // First bit is already on spi_sdo; this only times CS fall to the first rising edge.
      ST_SETUP: begin
        if (cnt_zero) begin
          sck_d   = 1'b1;
          cnt_d   = HALF_LOAD;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      // Sample at the end of the high phase: the responder changes data on the falling edge,
      // so the registered copy is stable by now.
      ST_HIGH: begin
        if (cnt_zero) begin
          sck_d   = 1'b0;
          rx_sr_d = {rx_sr_q[6:0], sdi_q};
          if (bit_q == 3'd7) begin
            rx_data_d   = {rx_sr_q[6:0], sdi_q};
            rx_strobe_d = 1'b1;
            if (last_q) begin
              cnt_d   = HOLD_LOAD;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            sdo_d   = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            cnt_d   = HALF_LOAD;
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end

      ST_LOW: begin
        if (cnt_zero) begin
          sck_d   = 1'b1;
          cnt_d   = HALF_LOAD;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      // CS held low with SCK parked until the next byte of the frame arrives; no timeout.
      ST_WAIT: begin
        if (accept) begin
          tx_sr_d = tx_data;
          last_d  = tx_last;
          sdo_d   = tx_data[7];
          bit_d   = 3'd0;
          cnt_d   = HALF_LOAD;
          state_d = ST_LOW;
        end
      end

      ST_HOLD: begin
        if (cnt_zero) begin
          cs_d    = 1'b1;
          cnt_d   = IDLE_LOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      tx_sr_q     <= 8'h00;
      last_q      <= 1'b0;
      rx_sr_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      sdo_q       <= 1'b0;
      busy_q      <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_sr_q     <= tx_sr_d;
      last_q      <= last_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      sdo_q       <= sdo_d;
      busy_q      <= busy_d;
      sdi_q       <= spi_sdi;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign busy      = busy_q;
  assign spi_sck   = sck_q;
  assign spi_cs    = cs_q;
  assign spi_sdo   = sdo_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized bench with a mode-0 responder model and edge timing checks
module tb_spi_controller;

  localparam int P = 4;
  localparam int S = 4;
  localparam int H = 4;
  localparam int I = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       busy;
  logic       spi_sck;
  logic       spi_cs;
  logic       spi_sdo;
  logic       spi_sdi = 1'b0;

  always #5 clk = ~clk;

  spi_controller #(
    .CLOCKS_PER_HALF_BIT(P),
    .CS_SETUP_CLOCKS(S),
    .CS_HOLD_CLOCKS(H),
    .CS_IDLE_CLOCKS(I)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_last(tx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_strobe(rx_strobe),
    .busy(busy),
    .spi_sck(spi_sck),
    .spi_cs(spi_cs),
    .spi_sdo(spi_sdo),
    .spi_sdi(spi_sdi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the responder should see on MOSI and what the host should get back.
  logic [7:0] resp_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] frame_tx[$];
  logic [7:0] frame_rsp[$];

  // Mode-0 responder: drive MSB at CS fall, next bit on each SCK fall, sample MOSI on SCK rise.
  logic [7:0] r_sr = 8'h00;
  logic [7:0] r_in = 8'h00;
  int         r_bits = 0;
  int         frame_rises = 0;
  int         bad_rises = 0;
  int         extra_bytes = 0;
  logic       r_prev_cs = 1'b1;
  logic       r_prev_sck = 1'b0;

  always @(spi_cs or spi_sck) begin
    if (spi_cs === 1'b1 && r_prev_cs === 1'b0) begin
      r_bits = 0;
    end else if (spi_cs === 1'b0 && r_prev_cs !== 1'b0) begin
      r_bits = 0;
      frame_rises = 0;
      r_sr = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
      spi_sdi = r_sr[7];
    end else if (spi_sck === 1'b1 && r_prev_sck !== 1'b1) begin
      if (spi_cs !== 1'b0) begin
        bad_rises++;
      end else begin
        r_in = {r_in[6:0], spi_sdo};
        r_bits = (r_bits + 1) % 8;
        frame_rises++;
        if (r_bits == 0) begin
          if (exp_mosi.size() > 0) check("mosi_byte", 32'(r_in), 32'(exp_mosi.pop_front()));
          else extra_bytes++;
        end
      end
    end else if (spi_sck === 1'b0 && r_prev_sck === 1'b1 && spi_cs === 1'b0) begin
      if (r_bits == 0) r_sr = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
      else r_sr = {r_sr[6:0], 1'b0};
      spi_sdi = r_sr[7];
    end
    r_prev_cs = spi_cs;
    r_prev_sck = spi_sck;
  end

  // Received-byte scoreboard.
  int   strobes = 0;
  int   extra_strobes = 0;
  int   double_strobes = 0;
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (rx_strobe === 1'b1) begin
      strobes++;
      if (prev_strobe === 1'b1) double_strobes++;
      if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      else extra_strobes++;
    end
    prev_strobe = rx_strobe;
  end

  // Edge timing monitor, in clk cycles.
  int   cyc = 0;
  int   t_cs_fall = 0;
  int   t_cs_rise = -1;
  int   t_rise = 0;
  int   t_fall = 0;
  int   rises_m = 0;
  bit   mon_en = 1'b0;
  bit   expect_b2b = 1'b0;
  logic m_cs = 1'b1;
  logic m_sck = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (m_cs === 1'b1 && spi_cs === 1'b0) begin
        t_cs_fall = cyc;
        rises_m = 0;
        if (t_cs_rise >= 0) check("cs_idle_min", 32'(cyc - t_cs_rise >= I), 1);
      end
      if (m_sck === 1'b0 && spi_sck === 1'b1) begin
        if (rises_m == 0) check("cs_setup", 32'(cyc - t_cs_fall), S);
        else if (rises_m % 8 != 0) check("sck_low", 32'(cyc - t_fall), P);
        else if (expect_b2b) check("byte_gap", 32'(cyc - t_fall), P + 1);
        else check("byte_gap_min", 32'(cyc - t_fall >= P + 1), 1);
        rises_m++;
        t_rise = cyc;
      end
      if (m_sck === 1'b1 && spi_sck === 1'b0) begin
        check("sck_high", 32'(cyc - t_rise), P);
        t_fall = cyc;
      end
      if (m_cs === 1'b0 && spi_cs === 1'b1) begin
        check("cs_hold", 32'(cyc - t_fall), H);
        t_cs_rise = cyc;
      end
    end
    m_cs = spi_cs;
    m_sck = spi_sck;
  end

  task automatic push_byte(input logic [7:0] t, input logic [7:0] r);
    frame_tx.push_back(t);
    frame_rsp.push_back(r);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit hold_valid);
    int n = 0;
    tx_data = d;
    tx_last = last;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(tx_ready), 1);
    @(posedge clk);
    #1;
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("busy_clear", 32'(busy), 0);
  endtask

  task automatic wait_strobe();
    int n = 0;
    @(negedge clk);
    while (rx_strobe !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(rx_strobe), 1);
  endtask

  task automatic load_frame();
    for (int i = 0; i < frame_tx.size(); i++) begin
      resp_q.push_back(frame_rsp[i]);
      exp_rx.push_back(frame_rsp[i]);
      exp_mosi.push_back(frame_tx[i]);
    end
  endtask

  // Runs frame_tx/frame_rsp; late == 0 keeps tx_valid high between bytes.
  task automatic run_frame(input int late);
    int n = frame_tx.size();
    int bad = 0;
    load_frame();
    expect_b2b = (late == 0);
    for (int i = 0; i < n; i++) begin
      send_byte(frame_tx[i], (i == n - 1), (late == 0) && (i < n - 1));
      if (i == 0) check("busy_after_accept", 32'(busy), 1);
      if (late > 0 && i < n - 1) begin
        wait_strobe();
        bad = 0;
        for (int k = 0; k < late; k++) begin
          @(negedge clk);
          if (tx_ready !== 1'b1 || spi_cs !== 1'b0 || spi_sck !== 1'b0) bad++;
        end
        check("wait_state_hold", 32'(bad), 0);
      end
    end
    wait_idle();
    check("sck_rises", 32'(frame_rises), 32'(8 * n));
    check("rx_drained", 32'(exp_rx.size()), 0);
    check("mosi_drained", 32'(exp_mosi.size()), 0);
    frame_tx.delete();
    frame_rsp.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nb;
    int late;
    int bad;
    int strobes_before;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(spi_cs), 1);
    check("rst_sck", 32'(spi_sck), 0);
    check("rst_sdo", 32'(spi_sdo), 0);
    check("rst_strobe", 32'(rx_strobe), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_tx_ready", 32'(tx_ready), 1);
    mon_en = 1'b1;

    // Single byte 0xA5, responder returns 0x3C.
    push_byte(8'hA5, 8'h3C);
    run_frame(0);

    // Three-byte back-to-back frame.
    push_byte(8'h01, 8'($urandom));
    push_byte(8'h02, 8'($urandom));
    push_byte(8'h03, 8'($urandom));
    run_frame(0);

    // Second byte offered 50 clk late.
    push_byte(8'($urandom), 8'($urandom));
    push_byte(8'($urandom), 8'($urandom));
    run_frame(50);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      nb = int'($urandom_range(1, 4));
      late = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      for (int i = 0; i < nb; i++) push_byte(8'($urandom), 8'($urandom));
      run_frame(late);
    end

    // tx_valid pulsed during the CS idle gap must be ignored.
    push_byte(8'h99, 8'h66);
    load_frame();
    expect_b2b = 1'b0;
    send_byte(8'h99, 1'b1, 1'b0);
    bad = 0;
    while (spi_cs !== 1'b1 && bad < 2000) begin
      @(negedge clk);
      bad++;
    end
    check("cs_rise_seen", 32'(spi_cs), 1);
    tx_data = 8'h77;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (tx_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("gap_not_ready", 32'(bad), 0);
    wait_idle();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (spi_cs !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("gap_pulse_ignored", 32'(bad), 0);
    check("gap_frame_rises", 32'(frame_rises), 8);
    frame_tx.delete();
    frame_rsp.delete();
    push_byte(8'h77, 8'($urandom));
    run_frame(0);

    // Reset after the third SCK rising edge.
    push_byte(8'h5A, 8'hC3);
    load_frame();
    send_byte(8'h5A, 1'b1, 1'b0);
    bad = 0;
    while (frame_rises < 3 && bad < 2000) begin
      @(negedge clk);
      bad++;
    end
    check("third_rise_seen", 32'(frame_rises), 3);
    mon_en = 1'b0;
    reset = 1'b1;
    strobes_before = strobes;
    @(posedge clk);
    #1;
    check("midrst_cs", 32'(spi_cs), 1);
    check("midrst_sck", 32'(spi_sck), 0);
    check("midrst_strobe", 32'(rx_strobe), 0);
    check("midrst_tx_ready", 32'(tx_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_rx.delete();
    exp_mosi.delete();
    resp_q.delete();
    frame_tx.delete();
    frame_rsp.delete();
    repeat (20) @(negedge clk);
    check("midrst_no_strobe", 32'(strobes), 32'(strobes_before));
    check("midrst_idle_ready", 32'(tx_ready), 1);
    t_cs_rise = -1;
    mon_en = 1'b1;
    push_byte(8'hFF, 8'($urandom));
    run_frame(0);

    repeat (10) @(negedge clk);
    check("sck_while_cs_high", 32'(bad_rises), 0);
    check("extra_strobes", 32'(extra_strobes), 0);
    check("double_strobes", 32'(double_strobes), 0);
    check("extra_mosi_bytes", 32'(extra_bytes), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
